// File: rtl/eq_sample_feeder_pkg.sv
// Shared types for the EQ sample feeder: FSM states and the control-plane status record.
package eq_sample_feeder_pkg;

  localparam int SAMPLE_W  = 24;
  // Status counters are carried at this width; the top clamps them to its CNT_W.
  localparam int MAX_CNT_W = 32;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } feeder_state_t;

  typedef struct packed {
    logic                 underrun;
    logic                 overflow;
    logic [MAX_CNT_W-1:0] underrun_cnt;
    logic [MAX_CNT_W-1:0] overflow_cnt;
  } feeder_status_t;

endpackage

// File: rtl/sample_fifo.sv
// Single-clock synchronous FIFO with occupancy count; head word is visible combinationally on rd_data.
module sample_fifo #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     wr_en,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     rd_en,
  output logic signed [DATA_W-1:0] rd_data,
  output logic [PTR_W:0]           count
);

  logic signed [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic                     do_wr;
  logic                     do_rd;

  // Guards are decided on the registered count only, so a full FIFO never accepts a write.
  assign do_wr   = wr_en && (count != (PTR_W+1)'(DEPTH));
  assign do_rd   = rd_en && (count != '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/eq_sample_feeder.sv
// Responder for the EQ sample-request interface: FIFO-buffered samples, one-cycle delivery strobe,
// a single merged pending request on underrun, and sticky/saturating underrun and overflow status.
module eq_sample_feeder
  import eq_sample_feeder_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                     alg_clk,
  input  logic                     resetn,
  input  logic signed [DATA_W-1:0] in_sample,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     send_next_sample,
  output logic signed [DATA_W-1:0] sample_data,
  output logic                     sample_valid,
  output logic [LVL_W-1:0]         fill_level,
  output logic                     underrun,
  output logic                     overflow,
  output logic [CNT_W-1:0]         underrun_cnt,
  output logic [CNT_W-1:0]         overflow_cnt,
  input  logic                     clear_status
);

  localparam logic [MAX_CNT_W-1:0] CNT_MAX = MAX_CNT_W'((64'd1 << CNT_W) - 64'd1);

  logic [LVL_W-1:0]         count;
  logic signed [DATA_W-1:0] head_p0;
  logic                     wr_p0;
  logic                     drop_p0;
  logic                     pop_p0;
  logic                     ur_event_p0;
  feeder_state_t            state_q;
  feeder_state_t            state_d;
  feeder_status_t           status_q;
  feeder_status_t           status_d;

  function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] value);
    return (value == CNT_MAX) ? value : value + 1'b1;
  endfunction

  assign in_ready = (count < LVL_W'(DEPTH));
  assign wr_p0    = in_valid && in_ready;
  assign drop_p0  = in_valid && !in_ready;

  sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (alg_clk),
    .resetn  (resetn),
    .wr_en   (wr_p0),
    .wr_data (in_sample),
    .rd_en   (pop_p0),
    .rd_data (head_p0),
    .count   (count)
  );

  always_comb begin
    state_d     = state_q;
    pop_p0      = 1'b0;
    ur_event_p0 = 1'b0;
    case (state_q)
      IDLE: begin
        if (send_next_sample) begin
          if (count != '0) begin
            pop_p0 = 1'b1;
          end else begin
            state_d     = PENDING;
            ur_event_p0 = 1'b1;
          end
        end
      end
      PENDING: begin
        // Extra requests fold into the one outstanding request but are still reported.
        ur_event_p0 = send_next_sample;
        if (count != '0) begin
          pop_p0  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    status_d = status_q;
    if (ur_event_p0) begin
      status_d.underrun     = 1'b1;
      status_d.underrun_cnt = sat_inc(status_q.underrun_cnt);
    end
    if (drop_p0) begin
      status_d.overflow     = 1'b1;
      status_d.overflow_cnt = sat_inc(status_q.overflow_cnt);
    end
    if (clear_status) status_d = '0;
  end

  // Stage boundary: pop decided this cycle, sample delivered on the next.
  always_ff @(posedge alg_clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      status_q     <= '0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      sample_valid <= pop_p0;
      if (pop_p0) sample_data <= head_p0;
    end
  end

  assign fill_level   = count;
  assign underrun     = status_q.underrun;
  assign overflow     = status_q.overflow;
  assign underrun_cnt = status_q.underrun_cnt[CNT_W-1:0];
  assign overflow_cnt = status_q.overflow_cnt[CNT_W-1:0];

endmodule

// File: tb/tb_eq_sample_feeder.sv
// Directed bench for eq_sample_feeder: queue-based reference model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_eq_sample_feeder;

  localparam int DW    = 24;
  localparam int DEP   = 16;
  localparam int CW    = 3;
  localparam int CMAX  = 7;

  logic          alg_clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] in_sample;
  logic          in_valid;
  logic          in_ready;
  logic          send_next_sample;
  logic [DW-1:0] sample_data;
  logic          sample_valid;
  logic [4:0]    fill_level;
  logic          underrun;
  logic          overflow;
  logic [CW-1:0] underrun_cnt;
  logic [CW-1:0] overflow_cnt;
  logic          clear_status;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  eq_sample_feeder #(.DATA_W(DW), .DEPTH(DEP), .CNT_W(CW)) dut (
    .alg_clk          (alg_clk),
    .resetn           (resetn),
    .in_sample        (in_sample),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .send_next_sample (send_next_sample),
    .sample_data      (sample_data),
    .sample_valid     (sample_valid),
    .fill_level       (fill_level),
    .underrun         (underrun),
    .overflow         (overflow),
    .underrun_cnt     (underrun_cnt),
    .overflow_cnt     (overflow_cnt),
    .clear_status     (clear_status)
  );

  always #5 alg_clk = ~alg_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of buffered samples and one outstanding-request bit.
  logic [DW-1:0] q[$];
  bit            pend;
  bit            m_valid;
  logic [DW-1:0] m_data;
  bit            m_ur, m_ov;
  int            m_urc, m_ovc;
  bit            have, full, serve, ev_ur, ev_ov;

  always @(posedge alg_clk) begin
    if (!resetn) begin
      q.delete();
      pend = 0; m_valid = 0; m_data = '0;
      m_ur = 0; m_ov = 0; m_urc = 0; m_ovc = 0;
    end else begin
      have  = q.size() > 0;
      full  = q.size() >= DEP;
      // A request underruns when nothing is buffered or one is already waiting.
      ev_ur = send_next_sample && (pend || !have);
      serve = have && (pend || send_next_sample);
      ev_ov = in_valid && full;
      if (!have && send_next_sample) pend = 1;
      else if (serve) pend = 0;
      m_valid = serve;
      if (serve) m_data = q.pop_front();
      if (in_valid && !full) q.push_back(in_sample);
      if (clear_status) begin
        m_ur = 0; m_ov = 0; m_urc = 0; m_ovc = 0;
      end else begin
        if (ev_ur) begin m_ur = 1; if (m_urc < CMAX) m_urc++; end
        if (ev_ov) begin m_ov = 1; if (m_ovc < CMAX) m_ovc++; end
      end
    end
  end

  always @(negedge alg_clk) begin
    if (chk_en) begin
      check("valid", sample_valid, m_valid);
      check("data", sample_data, m_data);
      check("fill", fill_level, q.size());
      check("in_ready", in_ready, q.size() < DEP);
      check("underrun", underrun, m_ur);
      check("overflow", overflow, m_ov);
      check("underrun_cnt", underrun_cnt, m_urc);
      check("overflow_cnt", overflow_cnt, m_ovc);
    end
  end

  task automatic tick();
    @(posedge alg_clk);
    #1;
  endtask

  task automatic clear();
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
  endtask

  int nval;

  initial begin
    resetn = 1'b0; in_sample = '0; in_valid = 1'b0;
    send_next_sample = 1'b0; clear_status = 1'b0;
    tick(); tick();
    chk_en = 1'b1;
    check("rst_ready", in_ready, 1);
    check("rst_fill", fill_level, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_data", sample_data, 0);
    resetn = 1'b1;

    // In-order delivery of four buffered samples
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_sample = DW'(i); tick();
    end
    in_valid = 1'b0;
    check("t1_fill4", fill_level, 4);
    for (int i = 1; i <= 4; i++) begin
      send_next_sample = 1'b1; tick();
      check("t1_valid", sample_valid, 1);
      check("t1_data", sample_data, i);
      check("t1_fill", fill_level, 4 - i);
    end
    send_next_sample = 1'b0; tick();
    check("t1_idle", sample_valid, 0);

    // Underrun, then a late write satisfies the pending request
    send_next_sample = 1'b1; tick(); send_next_sample = 1'b0;
    check("t2_ur", underrun, 1);
    check("t2_urc", underrun_cnt, 1);
    repeat (5) tick();
    in_valid = 1'b1; in_sample = 24'h7FFFFF; tick(); in_valid = 1'b0;
    check("t2_w1_valid", sample_valid, 0);
    check("t2_w1_fill", fill_level, 1);
    tick();
    check("t2_w2_valid", sample_valid, 1);
    check("t2_w2_data", sample_data, 24'h7FFFFF);
    tick();
    check("t2_after", sample_valid, 0);
    check("t2_hold", sample_data, 24'h7FFFFF);
    clear();

    // Three merged requests yield one delivery
    send_next_sample = 1'b1; repeat (3) tick(); send_next_sample = 1'b0;
    in_valid = 1'b1; in_sample = 24'hABCDEF; tick(); in_valid = 1'b0;
    tick();
    check("t3_valid", sample_valid, 1);
    check("t3_data", sample_data, 24'hABCDEF);
    nval = 0;
    repeat (4) begin tick(); if (sample_valid) nval++; end
    check("t3_single", nval, 0);
    check("t3_urc", underrun_cnt, 3);
    clear();

    // Overflow while full, with a same-cycle read
    for (int i = 0; i < DEP; i++) begin
      in_valid = 1'b1; in_sample = DW'(24'h100 + i); tick();
    end
    check("t4_full_ready", in_ready, 0);
    check("t4_full_fill", fill_level, 16);
    in_sample = 24'h123456; send_next_sample = 1'b1; tick();
    in_valid = 1'b0;
    check("t4_ov", overflow, 1);
    check("t4_ovc", overflow_cnt, 1);
    check("t4_first", sample_data, 24'h100);
    check("t4_fill", fill_level, 15);
    for (int i = 1; i < DEP; i++) begin
      tick();
      check("t4_data", sample_data, 24'h100 + i);
    end
    send_next_sample = 1'b0; tick();
    check("t4_empty", fill_level, 0);
    clear();

    // Sustained requests drain the FIFO then underrun
    for (int i = 0; i < DEP; i++) begin
      in_valid = 1'b1; in_sample = DW'(24'h200 + i); tick();
    end
    in_valid = 1'b0;
    send_next_sample = 1'b1; nval = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sample_valid) nval++;
      if (i < DEP) check("t5_data", sample_data, 24'h200 + i);
    end
    send_next_sample = 1'b0;
    check("t5_nval", nval, 16);
    check("t5_ur", underrun, 1);
    check("t5_urc", underrun_cnt, 4);
    clear();
    check("t5_clr_ur", underrun, 0);
    check("t5_clr_urc", underrun_cnt, 0);
    check("t5_clr_ov", overflow, 0);
    check("t5_clr_ovc", overflow_cnt, 0);

    // Writes resolve the leftover pending request, then reset mid-stream
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_sample = DW'(24'h300 + i); tick();
    end
    in_valid = 1'b0;
    check("t6_fill", fill_level, 7);
    send_next_sample = 1'b1; tick();
    check("t6_data", sample_data, 24'h301);
    resetn = 1'b0; tick();
    resetn = 1'b1; send_next_sample = 1'b0;
    check("t6_rst_valid", sample_valid, 0);
    check("t6_rst_fill", fill_level, 0);
    check("t6_rst_ready", in_ready, 1);
    tick();
    check("t6_post_valid", sample_valid, 0);
    in_valid = 1'b1; in_sample = 24'h0BEEF0; tick(); in_valid = 1'b0;
    send_next_sample = 1'b1; tick(); send_next_sample = 1'b0;
    check("t6_new_valid", sample_valid, 1);
    check("t6_new_data", sample_data, 24'h0BEEF0);
    tick();

    // Counter saturation, clear winning over a same-cycle event
    send_next_sample = 1'b1; repeat (10) tick();
    check("t7_sat", underrun_cnt, 7);
    clear_status = 1'b1; tick(); clear_status = 1'b0; send_next_sample = 1'b0;
    check("t7_clr_ur", underrun, 0);
    check("t7_clr_urc", underrun_cnt, 0);
    in_valid = 1'b1; in_sample = 24'h800001; tick(); in_valid = 1'b0;
    tick();
    check("t7_neg_valid", sample_valid, 1);
    check("t7_neg_data", sample_data, 24'h800001);
    tick(); tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
